wptr_full_ctrl: RTL and testbench
=================================

Name: wptr_full_ctrl

Overview:
Write-domain pointer and flag controller for the asynchronous FIFO. It consumes the 2-flop-synchronised Gray read pointer (wq2_rptr) and maintains the binary and Gray write pointers. It produces the memory write address and write enable, plus the full, almost-full, fill-level and sticky-overflow status. It sits between the write-side client, the dual-port RAM and the read-to-write synchroniser, and exports wptr for the write-to-read synchroniser.

Parameters:
ADDRSIZE, 3, address width; FIFO depth = 2^ADDRSIZE; legal values are 2 and above.
AFULL_THRESH, 6, fill level at or above which walmost_full asserts; legal range 1 to 2^ADDRSIZE.

Ports:
wclk  input  1  write-domain clock
wrst  input  1  asynchronous, active-high reset
winc  input  1  write request from client, sampled each wclk
wovf_clr  input  1  clears the sticky overflow flag
wq2_rptr  input  ADDRSIZE+1  Gray read pointer, already synchronised to wclk
wen  output  1  RAM write enable (combinational)
waddr  output  ADDRSIZE  RAM write address
wptr  output  ADDRSIZE+1  Gray write pointer, registered, sent to the write-to-read synchroniser
wfull  output  1  FIFO full, registered
walmost_full  output  1  level at or above AFULL_THRESH, registered
wlevel  output  ADDRSIZE+1  pessimistic fill level, registered, range 0 to 2^ADDRSIZE
wovf  output  1  sticky overflow: a write was attempted while full

Behaviour:
- Reset (wrst=1, asynchronous, takes effect immediately):
  - The internal binary pointer wbin, plus wptr, waddr, wfull, walmost_full, wlevel and wovf, all go to 0.
  - wen goes to 0 because it is gated by reset.
- Write acceptance:
  - wen = winc & ~wfull & ~wrst.
  - The RAM captures the data at waddr on the same wclk edge.
- Pointer update:
  - wbinnext = wbin + wen, modulo 2^(ADDRSIZE+1).
  - wgraynext = (wbinnext >> 1) ^ wbinnext.
  - wbin, wptr <= wbinnext, wgraynext on every edge.
  - waddr = wbin[ADDRSIZE-1:0].
  - wptr changes by at most one bit per cycle.
- Full flag:
  - wfull <= (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
  - wfull asserts on the edge that accepts the last free slot. No write is lost or duplicated.
- Level:
  - rbin_s = Gray-to-binary of wq2_rptr (combinational XOR prefix, MSB first).
  - wlevel <= wbinnext - rbin_s, computed modulo 2^(ADDRSIZE+1).
  - Because rptr is seen two or more wclk late, wlevel is an upper bound on true occupancy and never an underestimate.
- Almost-full:
  - walmost_full <= ((wbinnext - rbin_s) >= AFULL_THRESH), using the same next-state value as wlevel.
- Overflow:
  - Set condition: winc & wfull.
  - Next value: wovf <= set | (wovf & ~wovf_clr).
  - If set and clear occur in the same cycle, set wins.
  - A rejected write never moves the pointers.
- Deassertion latency:
  - A read seen on wq2_rptr clears wfull, and updates wlevel and walmost_full, one wclk after wq2_rptr changes.
- Wrap-around:
  - The pointer MSB toggles every 2^ADDRSIZE writes.
  - Full versus empty is distinguished only by the top two Gray bits.
  - Wrap must not produce a false full or a false level.
- Simultaneous events:
  - A write and a read update in the same cycle leave wlevel unchanged and recompute wfull correctly.
  - If the FIFO is full and a read appears on the same edge as winc, that write is still rejected, because wfull is registered.
- Reset mid-operation:
  - Everything clears asynchronously.
  - The read side must be reset in the same window; this block does not check that.

Decomposition:
- Shared package fifo_pkg holds:
  - functions bin2gray and gray2bin, parameterised by width;
  - constant DEFAULT_ADDRSIZE = 3.
- The existing read-domain pointer/empty block reuses the same functions.
- One sub-module is natural: gray2bin_comb, a combinational Gray-to-binary converter of width ADDRSIZE+1, used for rbin_s.
- Everything else lives in wptr_full_ctrl.

Test Plan:
(All scenarios use ADDRSIZE=3, AFULL_THRESH=6.)
1. Reset check: assert wrst for 3 cycles while winc=1 -> wen=0, and wptr, waddr, wlevel, wfull, walmost_full and wovf all read 0.
2. Fill with no reads: 8 consecutive writes, wq2_rptr=4'b0000.
   - walmost_full rises after the 6th accepted write.
   - After the 8th write: wfull=1, wlevel=8, wptr=4'b1100, waddr=3'b000.
3. Overflow: while full, winc=1 for 2 cycles.
   - wen=0 and wptr holds at 4'b1100.
   - wovf=1 and stays 1 after winc drops.
   - wovf_clr=1 alone -> wovf=0.
   - wovf_clr together with a new overflow attempt -> wovf=1.
4. Drain one entry: from full, set wq2_rptr=4'b0001 (Gray of 1) -> next cycle wfull=0 and wlevel=7; walmost_full stays 1.
5. Wrap-around: 20 write/read pairs with wq2_rptr tracking wptr with a 2-cycle lag.
   - wptr passes 4'b1000 (Gray of 15) to 4'b0000.
   - wfull is never asserted and wlevel stays at or below 2.
   - A scoreboard confirms waddr increments modulo 8.
6. Asynchronous reset while full: assert wrst between clock edges -> all outputs go to 0 before the next wclk edge, and the first write after release uses waddr=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary pointer conversion used by both the
// write-domain and read-domain pointer controllers.
package fifo_pkg;

    localparam int DEFAULT_ADDRSIZE = 3;
    localparam int MAX_PTR_W        = 32;

    // Both functions work for any pointer width up to MAX_PTR_W as long as the
    // caller zero-extends the input and truncates the result to its own width.
    function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] gray);
        logic [MAX_PTR_W-1:0] bin;
        bin = '0;
        for (int i = 0; i < MAX_PTR_W; i++) begin
            bin[i] = ^(gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits from the MSB down to that position.
module gray2bin_comb #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer and full/level/overflow controller for the async FIFO.
// Consumes the synchronised Gray read pointer and owns the write pointers.
module wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE     = DEFAULT_ADDRSIZE,
    parameter int AFULL_THRESH = 6
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic                wovf_clr,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    output logic                wen,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                wovf
);

    localparam int PW = ADDRSIZE + 1;

    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wbinnext;
    logic [ADDRSIZE:0] wgraynext;
    logic [ADDRSIZE:0] rbin_s;
    logic [ADDRSIZE:0] level_next;
    logic [ADDRSIZE:0] full_match;
    logic              full_next;
    logic              afull_next;
    logic              ovf_set;

    gray2bin_comb #(
        .WIDTH (PW)
    ) u_rptr_bin (
        .gray (wq2_rptr),
        .bin  (rbin_s)
    );

    // Reset gating keeps the RAM from capturing during an async reset window.
    assign wen   = winc & ~wfull & ~wrst;
    assign waddr = wbin[ADDRSIZE-1:0];

    // Full when the write pointer is exactly one lap ahead of the read pointer,
    // which in Gray code means the top two bits are inverted and the rest equal.
    always_comb begin
        wbinnext   = wbin + {{ADDRSIZE{1'b0}}, wen};
        wgraynext  = PW'(bin2gray(MAX_PTR_W'(wbinnext)));
        level_next = wbinnext - rbin_s;
        full_match = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
        full_next  = (wgraynext == full_match);
        afull_next = (level_next >= PW'(AFULL_THRESH));
        ovf_set    = winc & wfull;
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
            wovf         <= 1'b0;
        end else begin
            wbin         <= wbinnext;
            wptr         <= wgraynext;
            wfull        <= full_next;
            walmost_full <= afull_next;
            wlevel       <= level_next;
            wovf         <= ovf_set | (wovf & ~wovf_clr);
        end
    end

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed bench for wptr_full_ctrl with an occupancy-count reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_wptr_full_ctrl;

    localparam int ADDRSIZE     = 3;
    localparam int AFULL_THRESH = 6;
    localparam int DEPTH        = 1 << ADDRSIZE;

    logic                wclk;
    logic                wrst;
    logic                winc;
    logic                wovf_clr;
    logic [ADDRSIZE:0]   wq2_rptr;
    logic                wen;
    logic [ADDRSIZE-1:0] waddr;
    logic [ADDRSIZE:0]   wptr;
    logic                wfull;
    logic                walmost_full;
    logic [ADDRSIZE:0]   wlevel;
    logic                wovf;

    int n_checks = 0;
    int n_fail   = 0;

    // Read side is modelled as a running count of entries consumed.
    int rd_count = 0;

    // Reference model state: total accepted writes and registered flags.
    int m_wr    = 0;
    int m_level = 0;
    bit m_full  = 0;
    bit m_afull = 0;
    bit m_ovf   = 0;

    logic [3:0] prev_wptr = '0;
    bit         wrap_seen = 0;

    function automatic logic [3:0] gray4(input int n);
        logic [3:0] b;
        b = 4'(n % 16);
        return b ^ (b >> 1);
    endfunction

    assign wq2_rptr = gray4(rd_count);

    wptr_full_ctrl #(
        .ADDRSIZE     (ADDRSIZE),
        .AFULL_THRESH (AFULL_THRESH)
    ) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .winc         (winc),
        .wovf_clr     (wovf_clr),
        .wq2_rptr     (wq2_rptr),
        .wen          (wen),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .wovf         (wovf)
    );

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic apply_stimulus(input bit inc, input bit clr, input int cycles);
        winc     = inc;
        wovf_clr = clr;
        for (int i = 0; i < cycles; i++) tick();
    endtask

    // Model: occupancy is accepted writes minus reads visible at the edge.
    always @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            m_wr    <= 0;
            m_level <= 0;
            m_full  <= 0;
            m_afull <= 0;
            m_ovf   <= 0;
        end else begin
            int wr_after;
            int lvl;
            wr_after = m_wr + ((winc && !m_full) ? 1 : 0);
            lvl      = wr_after - rd_count;
            m_wr    <= wr_after;
            m_level <= lvl;
            m_full  <= (lvl == DEPTH);
            m_afull <= (lvl >= AFULL_THRESH);
            m_ovf   <= (winc && m_full) || (m_ovf && !wovf_clr);
        end
    end

    always @(negedge wclk) begin
        check_output("wen",          32'(wen),          32'(winc && !m_full && !wrst));
        check_output("wptr",         32'(wptr),         32'(gray4(m_wr)));
        check_output("waddr",        32'(waddr),        32'(m_wr % DEPTH));
        check_output("wfull",        32'(wfull),        32'(m_full));
        check_output("walmost_full", 32'(walmost_full), 32'(m_afull));
        check_output("wlevel",       32'(wlevel),       32'(m_level));
        check_output("wovf",         32'(wovf),         32'(m_ovf));
        if (prev_wptr == 4'b1000 && wptr == 4'b0000) wrap_seen = 1;
        prev_wptr = wptr;
    end

    initial begin
        wrst     = 1'b1;
        winc     = 1'b1;
        wovf_clr = 1'b0;

        // Reset held with a pending write request.
        tick(); tick(); tick();
        check_output("rst_wen",   32'(wen),          32'h0);
        check_output("rst_wptr",  32'(wptr),         32'h0);
        check_output("rst_waddr", 32'(waddr),        32'h0);
        check_output("rst_level", 32'(wlevel),       32'h0);
        check_output("rst_full",  32'(wfull),        32'h0);
        check_output("rst_afull", 32'(walmost_full), 32'h0);
        check_output("rst_ovf",   32'(wovf),         32'h0);
        wrst = 1'b0;
        apply_stimulus(0, 0, 1);

        // Fill without reads.
        apply_stimulus(1, 0, 5);
        check_output("afull_after5", 32'(walmost_full), 32'h0);
        apply_stimulus(1, 0, 1);
        check_output("afull_after6", 32'(walmost_full), 32'h1);
        apply_stimulus(1, 0, 2);
        check_output("fill_full",  32'(wfull),  32'h1);
        check_output("fill_level", 32'(wlevel), 32'h8);
        check_output("fill_wptr",  32'(wptr),   32'hc);
        check_output("fill_waddr", 32'(waddr),  32'h0);

        // Overflow attempts while full.
        check_output("ovf_wen", 32'(wen), 32'h0);
        apply_stimulus(1, 0, 2);
        check_output("ovf_wptr_hold", 32'(wptr), 32'hc);
        check_output("ovf_set",       32'(wovf), 32'h1);
        apply_stimulus(0, 0, 1);
        check_output("ovf_sticky", 32'(wovf), 32'h1);
        apply_stimulus(0, 1, 1);
        check_output("ovf_clr", 32'(wovf), 32'h0);
        apply_stimulus(1, 1, 1);
        check_output("ovf_set_wins", 32'(wovf), 32'h1);
        apply_stimulus(0, 0, 1);

        // One entry drained by the read side.
        rd_count = 1;
        apply_stimulus(0, 0, 1);
        check_output("drain_full",  32'(wfull),        32'h0);
        check_output("drain_level", 32'(wlevel),       32'h7);
        check_output("drain_afull", 32'(walmost_full), 32'h1);

        // Wrap-around with the read pointer trailing close behind.
        rd_count = 8;
        apply_stimulus(0, 0, 1);
        check_output("wrap_start_level", 32'(wlevel), 32'h0);
        for (int k = 1; k <= 20; k++) begin
            apply_stimulus(1, 0, 1);
            rd_count = 8 + k - 1;
            check_output("wrap_level_bound", 32'(wlevel <= 2), 32'h1);
            check_output("wrap_no_full",     32'(wfull),       32'h0);
        end
        apply_stimulus(0, 0, 1);
        check_output("wrap_seen", 32'(wrap_seen), 32'h1);

        // Refill to full, then reset asynchronously between edges.
        apply_stimulus(1, 0, 7);
        check_output("refill_full", 32'(wfull), 32'h1);
        winc = 1'b0;
        #2;
        wrst     = 1'b1;
        rd_count = 0;
        #1;
        check_output("arst_wptr",  32'(wptr),         32'h0);
        check_output("arst_waddr", 32'(waddr),        32'h0);
        check_output("arst_full",  32'(wfull),        32'h0);
        check_output("arst_afull", 32'(walmost_full), 32'h0);
        check_output("arst_level", 32'(wlevel),       32'h0);
        check_output("arst_ovf",   32'(wovf),         32'h0);
        check_output("arst_wen",   32'(wen),          32'h0);
        tick();
        wrst = 1'b0;
        winc = 1'b1;
        #1;
        check_output("post_rst_waddr", 32'(waddr), 32'h0);
        check_output("post_rst_wen",   32'(wen),   32'h1);
        apply_stimulus(1, 0, 1);
        check_output("post_rst_wptr",  32'(wptr),  32'h1);
        check_output("post_rst_waddr1", 32'(waddr), 32'h1);
        apply_stimulus(0, 0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
